color_matrix_3x3: RTL and testbench
===================================

Name: color_matrix_3x3

Overview:
- Parametrised 3x3 colour-space matrix with per-row offsets: out_k = sat(round(Σ a_kj·in_j / 2^F) + c_k).
- Next generation of the fixed RGB→YCbCr converter. Adds a runtime register-write coefficient interface, a shadow bank committed at frame start, rounding and saturation.
- Sits in the video filter chain between the pixel source and downstream filters. Carries de/hs/vs alongside the data with matched latency.

Parameters:
- PIXEL_WIDTH, 8, bits per colour component, unsigned.
- COE_WIDTH, 13, signed coefficient width, two's complement; must be ≥ COE_FRACTION_WIDTH+2.
- COE_FRACTION_WIDTH, 10, fractional bits of each coefficient (F).
- OFS_WIDTH, PIXEL_WIDTH+2, signed integer offset width.

Ports:
- clk, in, 1, pixel clock.
- rst, in, 1, synchronous, active-high reset.
- coe_wr_i, in, 1, coefficient write strobe.
- coe_addr_i, in, 4, write address: 0..8 = a00,a01,a02,a10,a11,a12,a20,a21,a22; 9..11 = c0,c1,c2; 12..15 ignored.
- coe_data_i, in, COE_WIDTH, write data. Offsets use the low OFS_WIDTH bits, sign-interpreted.
- coe_pending_o, out, 1, shadow bank holds an uncommitted write.
- c0_i / c1_i / c2_i, in, PIXEL_WIDTH each, input components (R,G,B order by convention).
- de_i, hs_i, vs_i, in, 1 each, input sync. vs_i=1 marks the active frame.
- bypass_i, in, 1, route inputs to outputs unchanged.
- c0_o / c1_o / c2_o, out, PIXEL_WIDTH each, output components.
- de_o, hs_o, vs_o, out, 1 each, delayed sync.

Behaviour:
- Two register banks: shadow (written by the port) and active (used by the datapath). Both reset to identity: diagonal coefficients = 2^F, off-diagonal = 0, offsets = 0.
- Write: on a clk edge with coe_wr_i=1 and coe_addr_i ≤ 11, shadow[addr] <= coe_data_i and coe_pending_o <= 1. Addresses 12..15 do nothing.
- Commit:
  - A vs_i rising edge is vs_i=1 with registered vs_q=0.
  - On that edge, if pending, active <= shadow and coe_pending_o <= 0.
  - The pixel sampled on that same edge still uses the old active bank; new values apply from the next edge onward.
  - A write on the same edge as a commit lands in shadow after the copy (old shadow is committed) and leaves coe_pending_o=1.
  - There is no commit mid-frame.
- Datapath, latency 4 cycles from input edge to output, fully pipelined, 1 pixel per clock, no stalls:
  - S1: 9 signed products. Each input is zero-extended to PIXEL_WIDTH+1 bits; product width PIXEL_WIDTH+1+COE_WIDTH.
  - S2: per row, sum of two products; third product registered.
  - S3: row sum + (c_k << F) + 2^(F-1). Accumulator has 3 bits of headroom beyond the product width plus OFS_WIDTH.
  - S4: arithmetic shift right by F (round half up); saturate to [0, 2^PIXEL_WIDTH−1].
- Sync: de/hs/vs each delayed by exactly 4 registers, independent of de_i. Data is computed every cycle; downstream qualifies it with de_o.
- Bypass: bypass_i is sampled with the pixel and delayed 4 cycles. When set, outputs are the inputs delayed 4 cycles, so latency is unchanged and a toggle mid-stream causes no glitch or gap.
- Reset:
  - All outputs, pipeline registers and vs_q go to 0; coe_pending_o = 0; both banks return to identity.
  - Reset mid-frame drops all in-flight pixels. After rst deasserts, the first output is valid 4 cycles after the first sampled input.

Test Plan:
- Reset default, no writes: input (10,20,30), de_i=1 → (10,20,30) with de_o=1 exactly 4 clocks later. Outputs are 0 during rst.
- BT.601 luma: write a00..a02 = 306, 601, 116, then raise vs_i. Input (255,255,255) → c0_o=255. Input (0,0,0) → c0_o=0. Input (100,100,100) → c0_o = (102300+512)>>10 = 100.
- Offset path: row1 = −174, −339, 512 and c1=128. Input (100,100,100) → c1_o = (−100+131072+512)>>10 = 128.
- Saturation low: row0 all −1127, input (255,255,255) → c0_o=0. Saturation high: a00=2048, others 0, input (200,0,0) → c0_o=255.
- Commit timing: write a00=512 mid-frame → coe_pending_o=1 and output is unchanged (r=100 → 100). After the next vs_i rising edge, pixel r=100 → 50 and coe_pending_o=0. A write on the same edge as the commit leaves coe_pending_o=1.
- Bypass and reset: toggle bypass_i every 3 pixels on a ramp → output equals input delayed 4 with no gaps. Assert rst mid-line → outputs 0 next edge, de_o=0, banks back to identity.

Source files
------------

// File: rtl/color_matrix_3x3.sv
// 3x3 colour-space matrix with per-row offsets, rounding and saturation.
// Shadow coefficient bank is committed to the active bank on a vs rising edge.
module color_matrix_3x3 #(
  parameter int PIXEL_WIDTH        = 8,
  parameter int COE_WIDTH          = 13,
  parameter int COE_FRACTION_WIDTH = 10,
  parameter int OFS_WIDTH          = PIXEL_WIDTH + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   coe_wr_i,
  input  logic [3:0]             coe_addr_i,
  input  logic [COE_WIDTH-1:0]   coe_data_i,
  output logic                   coe_pending_o,
  input  logic [PIXEL_WIDTH-1:0] c0_i,
  input  logic [PIXEL_WIDTH-1:0] c1_i,
  input  logic [PIXEL_WIDTH-1:0] c2_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  input  logic                   bypass_i,
  output logic [PIXEL_WIDTH-1:0] c0_o,
  output logic [PIXEL_WIDTH-1:0] c1_o,
  output logic [PIXEL_WIDTH-1:0] c2_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o
);

  localparam int F  = COE_FRACTION_WIDTH;
  localparam int PW = PIXEL_WIDTH + 1 + COE_WIDTH;
  localparam int AW = PW + 3 + OFS_WIDTH;
  localparam int XW = 3 * PIXEL_WIDTH;

  localparam logic signed [COE_WIDTH-1:0] ONE  = COE_WIDTH'(2 ** F);
  localparam logic signed [AW-1:0]        RND  = AW'(2 ** (F - 1));
  localparam logic signed [AW-1:0]        MAXV = AW'(2 ** PIXEL_WIDTH - 1);

  logic signed [COE_WIDTH-1:0] sh_a  [9];
  logic signed [COE_WIDTH-1:0] act_a [9];
  logic signed [OFS_WIDTH-1:0] sh_c  [3];
  logic signed [OFS_WIDTH-1:0] act_c [3];
  logic                        vs_q;
  logic                        pend;
  logic                        vs_rise;
  logic [1:0]                  c_idx;

  assign vs_rise       = vs_i & ~vs_q;
  assign c_idx         = 2'(coe_addr_i - 4'd9);
  assign coe_pending_o = pend;

  // Commit copies shadow first; a same-edge write then overrides shadow and re-arms pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b0;
      pend <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        sh_a[i]  <= (i % 4 == 0) ? ONE : '0;
        act_a[i] <= (i % 4 == 0) ? ONE : '0;
      end
      for (int i = 0; i < 3; i++) begin
        sh_c[i]  <= '0;
        act_c[i] <= '0;
      end
    end else begin
      vs_q <= vs_i;
      if (vs_rise && pend) begin
        act_a <= sh_a;
        act_c <= sh_c;
        pend  <= 1'b0;
      end
      if (coe_wr_i) begin
        if (coe_addr_i < 4'd9) begin
          sh_a[coe_addr_i] <= coe_data_i;
          pend             <= 1'b1;
        end else if (coe_addr_i <= 4'd11) begin
          sh_c[c_idx] <= coe_data_i[OFS_WIDTH-1:0];
          pend        <= 1'b1;
        end
      end
    end
  end

  logic signed [PIXEL_WIDTH:0]   in_s  [3];
  logic signed [PW-1:0]          p1    [9];
  logic signed [OFS_WIDTH-1:0]   ofs1  [3];
  logic signed [PW:0]            s2_sum[3];
  logic signed [PW-1:0]          s2_p  [3];
  logic signed [OFS_WIDTH-1:0]   ofs2  [3];
  logic signed [AW-1:0]          acc3  [3];
  logic signed [AW-1:0]          shr   [3];
  logic [PIXEL_WIDTH-1:0]        sat   [3];
  logic [XW-1:0]                 pix_d [3];
  logic                          byp_d [3];
  logic [2:0]                    sync_d[3];

  assign in_s[0] = {1'b0, c0_i};
  assign in_s[1] = {1'b0, c1_i};
  assign in_s[2] = {1'b0, c2_i};

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      shr[k] = acc3[k] >>> F;
      sat[k] = '0;
      if (shr[k] < 0)
        sat[k] = '0;
      else if (shr[k] > MAXV)
        sat[k] = '1;
      else
        sat[k] = shr[k][PIXEL_WIDTH-1:0];
    end
  end

  // Offsets travel with the pixel so a commit never splits one pixel across two banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) p1[i] <= '0;
      for (int k = 0; k < 3; k++) begin
        ofs1[k]   <= '0;
        ofs2[k]   <= '0;
        s2_sum[k] <= '0;
        s2_p[k]   <= '0;
        acc3[k]   <= '0;
        pix_d[k]  <= '0;
        byp_d[k]  <= 1'b0;
        sync_d[k] <= '0;
      end
      c0_o <= '0;
      c1_o <= '0;
      c2_o <= '0;
      de_o <= 1'b0;
      hs_o <= 1'b0;
      vs_o <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 3; j++)
          p1[k*3+j] <= PW'(in_s[j]) * PW'(act_a[k*3+j]);
        ofs1[k]   <= act_c[k];
        s2_sum[k] <= (PW+1)'(p1[k*3]) + (PW+1)'(p1[k*3+1]);
        s2_p[k]   <= p1[k*3+2];
        ofs2[k]   <= ofs1[k];
        acc3[k]   <= AW'(s2_sum[k]) + AW'(s2_p[k]) + (AW'(ofs2[k]) <<< F) + RND;
      end
      pix_d[0]  <= {c2_i, c1_i, c0_i};
      pix_d[1]  <= pix_d[0];
      pix_d[2]  <= pix_d[1];
      byp_d[0]  <= bypass_i;
      byp_d[1]  <= byp_d[0];
      byp_d[2]  <= byp_d[1];
      sync_d[0] <= {vs_i, hs_i, de_i};
      sync_d[1] <= sync_d[0];
      sync_d[2] <= sync_d[1];
      c0_o <= byp_d[2] ? pix_d[2][PIXEL_WIDTH-1:0]               : sat[0];
      c1_o <= byp_d[2] ? pix_d[2][2*PIXEL_WIDTH-1:PIXEL_WIDTH]   : sat[1];
      c2_o <= byp_d[2] ? pix_d[2][3*PIXEL_WIDTH-1:2*PIXEL_WIDTH] : sat[2];
      de_o <= sync_d[2][0];
      hs_o <= sync_d[2][1];
      vs_o <= sync_d[2][2];
    end
  end

endmodule

// File: tb/tb_color_matrix_3x3.sv
// Scoreboard bench for color_matrix_3x3: a cycle model pushes expected pixels,
// the checker pops them four clocks later and compares against the DUT.
module tb_color_matrix_3x3;

  logic        clk = 1'b0;
  logic        rst;
  logic        coe_wr_i;
  logic [3:0]  coe_addr_i;
  logic [12:0] coe_data_i;
  logic        coe_pending_o;
  logic [7:0]  c0_i, c1_i, c2_i;
  logic        de_i, hs_i, vs_i, bypass_i;
  logic [7:0]  c0_o, c1_o, c2_o;
  logic        de_o, hs_o, vs_o;

  always #5 clk = ~clk;

  color_matrix_3x3 dut (
    .clk(clk), .rst(rst),
    .coe_wr_i(coe_wr_i), .coe_addr_i(coe_addr_i), .coe_data_i(coe_data_i),
    .coe_pending_o(coe_pending_o),
    .c0_i(c0_i), .c1_i(c1_i), .c2_i(c2_i),
    .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .bypass_i(bypass_i),
    .c0_o(c0_o), .c1_o(c1_o), .c2_o(c2_o),
    .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
  );

  typedef struct {
    int e0, e1, e2, de, hs, vs;
    int l0, l1, l2;
  } exp_t;

  exp_t sbq[$];
  int   tests_run = 0;
  int   failed = 0;
  int   lit0 = -1, lit1 = -1, lit2 = -1;

  int   m_a[9], s_a[9], m_c[3], s_c[3];
  int   m_pend = 0;
  int   m_vsq = 0;
  int   in_rst = 1;

  task automatic check_val(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mrow(input int k, input int r, input int g, input int b);
    longint s;
    s = longint'(m_a[k*3]) * r + longint'(m_a[k*3+1]) * g + longint'(m_a[k*3+2]) * b
        + longint'(m_c[k]) * 1024 + 512;
    s = s >>> 10;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return int'(s);
  endfunction

  // Reference model: evaluates each sampled pixel with the bank in force before this edge.
  always @(posedge clk) begin
    exp_t       e;
    logic [9:0] d10;
    in_rst = int'(rst);
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        m_a[i] = (i % 4 == 0) ? 1024 : 0;
        s_a[i] = m_a[i];
      end
      for (int i = 0; i < 3; i++) begin
        m_c[i] = 0;
        s_c[i] = 0;
      end
      m_pend = 0;
      m_vsq  = 0;
      sbq.delete();
    end else begin
      if (bypass_i) begin
        e.e0 = int'(c0_i); e.e1 = int'(c1_i); e.e2 = int'(c2_i);
      end else begin
        e.e0 = mrow(0, int'(c0_i), int'(c1_i), int'(c2_i));
        e.e1 = mrow(1, int'(c0_i), int'(c1_i), int'(c2_i));
        e.e2 = mrow(2, int'(c0_i), int'(c1_i), int'(c2_i));
      end
      e.de = int'(de_i); e.hs = int'(hs_i); e.vs = int'(vs_i);
      e.l0 = lit0; e.l1 = lit1; e.l2 = lit2;
      sbq.push_back(e);
      if (vs_i && m_vsq == 0 && m_pend != 0) begin
        m_a = s_a;
        m_c = s_c;
        m_pend = 0;
      end
      if (coe_wr_i && coe_addr_i <= 4'd11) begin
        if (coe_addr_i < 4'd9) begin
          s_a[coe_addr_i] = int'($signed(coe_data_i));
        end else begin
          d10 = coe_data_i[9:0];
          s_c[coe_addr_i - 4'd9] = int'($signed(d10));
        end
        m_pend = 1;
      end
      m_vsq = int'(vs_i);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (in_rst != 0) begin
      check_val("rst_c0", int'(c0_o), 0);
      check_val("rst_c1", int'(c1_o), 0);
      check_val("rst_c2", int'(c2_o), 0);
      check_val("rst_sync", int'({vs_o, hs_o, de_o}), 0);
      check_val("rst_pending", int'(coe_pending_o), 0);
    end else begin
      check_val("pending", int'(coe_pending_o), m_pend);
      if (sbq.size() >= 4) begin
        e = sbq.pop_front();
        check_val("c0", int'(c0_o), e.e0);
        check_val("c1", int'(c1_o), e.e1);
        check_val("c2", int'(c2_o), e.e2);
        check_val("de", int'(de_o), e.de);
        check_val("hs", int'(hs_o), e.hs);
        check_val("vs", int'(vs_o), e.vs);
        if (e.l0 >= 0) check_val("lit_c0", int'(c0_o), e.l0);
        if (e.l1 >= 0) check_val("lit_c1", int'(c1_o), e.l1);
        if (e.l2 >= 0) check_val("lit_c2", int'(c2_o), e.l2);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int r, input int g, input int b,
                     input int l0 = -1, input int l1 = -1, input int l2 = -1);
    c0_i = r[7:0]; c1_i = g[7:0]; c2_i = b[7:0];
    de_i = 1'b1;
    lit0 = l0; lit1 = l1; lit2 = l2;
    cyc();
    de_i = 1'b0;
    lit0 = -1; lit1 = -1; lit2 = -1;
  endtask

  task automatic wr(input int addr, input int data);
    coe_wr_i   = 1'b1;
    coe_addr_i = addr[3:0];
    coe_data_i = data[12:0];
    cyc();
    coe_wr_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; coe_wr_i = 1'b0; coe_addr_i = '0; coe_data_i = '0;
    c0_i = '0; c1_i = '0; c2_i = '0;
    de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; bypass_i = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;

    pix(10, 20, 30, 10, 20, 30);
    repeat (5) cyc();

    wr(13, 5);
    check_val("ignored_addr_pending", int'(coe_pending_o), 0);

    wr(0, 306); wr(1, 601); wr(2, 116);
    wr(3, -174); wr(4, -339); wr(5, 512); wr(10, 128);
    vs_i = 1'b1;
    pix(10, 20, 30, 10, 20, 30);
    pix(255, 255, 255, 255, 128, 255);
    pix(0, 0, 0, 0, 128, 0);
    pix(100, 100, 100, 100, 128, 100);
    vs_i = 1'b0;
    cyc();

    wr(0, -1127); wr(1, -1127); wr(2, -1127);
    vs_i = 1'b1;
    pix(1, 1, 1);
    pix(255, 255, 255, 0);
    vs_i = 1'b0;
    cyc();

    wr(0, 2048); wr(1, 0); wr(2, 0);
    vs_i = 1'b1;
    cyc();
    pix(200, 0, 0, 255);
    vs_i = 1'b0;
    cyc();

    wr(0, 1024);
    vs_i = 1'b1;
    cyc();
    wr(0, 512);
    check_val("pending_after_write", int'(coe_pending_o), 1);
    pix(100, 0, 0, 100);
    vs_i = 1'b0;
    cyc();
    vs_i = 1'b1;
    pix(100, 0, 0, 100);
    check_val("pending_after_commit", int'(coe_pending_o), 0);
    pix(100, 0, 0, 50);

    wr(0, 256);
    vs_i = 1'b0;
    cyc();
    vs_i = 1'b1;
    wr(0, 768);
    check_val("pending_same_edge", int'(coe_pending_o), 1);
    pix(100, 0, 0, 25);

    for (int i = 0; i < 18; i++) begin
      bypass_i = ((i / 3) % 2) != 0;
      hs_i     = (i % 5) == 0;
      if (bypass_i) pix(i * 10, i * 10 + 1, i * 10 + 2, i * 10, i * 10 + 1, i * 10 + 2);
      else          pix(i * 10, i * 10 + 1, i * 10 + 2);
    end
    bypass_i = 1'b0;
    hs_i     = 1'b0;

    pix(50, 60, 70);
    de_i = 1'b1;
    rst  = 1'b1;
    cyc();
    cyc();
    rst  = 1'b0;
    de_i = 1'b0;
    vs_i = 1'b0;
    pix(10, 20, 30, 10, 20, 30);
    repeat (8) cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
